// File: rtl/dma_descriptor_scheduler.sv
// dma_descriptor_scheduler: custom-instruction front end that stages DMA descriptors
// into a 4-deep FIFO and issues them one at a time to a DMA engine.
module dma_descriptor_scheduler #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic [31:0] dmaBusAddress,
  output logic [8:0]  dmaMemAddress,
  output logic [9:0]  dmaBlockSize,
  output logic [7:0]  dmaBurstSize,
  output logic        dmaStart,
  input  logic        dmaBusy,
  input  logic        dmaError
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HALT} state_e;
  state_e      state_q, state_d;
  logic [58:0] fifo_q [4];
  logic [1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] bus_q, bus_d;
  logic [8:0]  mem_q, mem_d;
  logic [9:0]  blk_q, blk_d;
  logic [7:0]  bst_q, bst_d;
  logic [58:0] dma_q, dma_d;
  logic        start_q, start_d, sticky_q, sticky_d;
  logic [7:0]  done_q, done_d, drop_q, drop_d;
  logic [3:0]  tmo_q, tmo_d;
  logic [2:0]  op;
  logic        sel, full, active, push, flush, clr, pop, ok_push, ok_pop, retire, fail;
  logic [31:0] status;
  logic        unused_bits;
  assign op          = ciValueA[2:0];
  assign unused_bits = ^ciValueA[31:3];
  assign sel         = ciStart && (ciN == customInstructionId);
  assign push        = sel && op == 3'd4;
  assign clr         = sel && op == 3'd6;
  assign flush       = sel && op == 3'd7;
  assign full        = cnt_q == 3'd4;
  assign active      = state_q != IDLE && state_q != HALT;
  assign ok_push     = push && !full;
  assign ok_pop      = pop && cnt_q != 3'd0;
  assign status      = {8'd0, drop_q, done_q, 2'b00, sticky_q, active, full, cnt_q};
  assign ciDone      = sel;
  assign ciResult    = (sel && op == 3'd5) ? status : 32'd0;
  assign dmaStart    = start_q;
  assign {dmaBusAddress, dmaMemAddress, dmaBlockSize, dmaBurstSize} = dma_q;
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    dma_d   = dma_q;
    start_d = 1'b0;
    pop     = 1'b0;
    retire  = 1'b0;
    fail    = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != 3'd0 && !sticky_q) begin
        state_d = ISSUE;
        start_d = 1'b1;
        dma_d   = fifo_q[rd_q];
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        tmo_d   = 4'd0;
      end
      WAIT_BUSY: if (dmaBusy) state_d = WAIT_DONE;
        else if (tmo_q == 4'd15) begin
          pop     = 1'b1;
          retire  = 1'b1;
          state_d = IDLE;
        end else tmo_d = tmo_q + 4'd1;
      WAIT_DONE: if (!dmaBusy) begin
        pop     = 1'b1;
        retire  = !dmaError;
        fail    = dmaError;
        state_d = dmaError ? HALT : IDLE;
      end
      HALT: if (clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // A flush drops everything, including a coincident pop of the in-flight head.
  always_comb begin
    bus_d    = (sel && op == 3'd0) ? ciValueB : bus_q;
    mem_d    = (sel && op == 3'd1) ? ciValueB[8:0] : mem_q;
    blk_d    = (sel && op == 3'd2) ? ciValueB[9:0] : blk_q;
    bst_d    = (sel && op == 3'd3) ? ciValueB[7:0] : bst_q;
    wr_d     = flush ? 2'd0 : wr_q + {1'b0, ok_push};
    rd_d     = flush ? 2'd0 : rd_q + {1'b0, ok_pop};
    cnt_d    = flush ? 3'd0 : cnt_q + {2'd0, ok_push} - {2'd0, ok_pop};
    done_d   = clr ? 8'd0 : done_q + {7'd0, retire && done_q != 8'hFF};
    drop_d   = clr ? 8'd0 : drop_q + {7'd0, push && full && drop_q != 8'hFF};
    sticky_d = fail || (sticky_q && !clr);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_q     <= 2'd0;
      rd_q     <= 2'd0;
      cnt_q    <= 3'd0;
      bus_q    <= 32'd0;
      mem_q    <= 9'd0;
      blk_q    <= 10'd0;
      bst_q    <= 8'd0;
      dma_q    <= 59'd0;
      start_q  <= 1'b0;
      sticky_q <= 1'b0;
      done_q   <= 8'd0;
      drop_q   <= 8'd0;
      tmo_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      bus_q    <= bus_d;
      mem_q    <= mem_d;
      blk_q    <= blk_d;
      bst_q    <= bst_d;
      dma_q    <= dma_d;
      start_q  <= start_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      tmo_q    <= tmo_d;
    end
  end
  always_ff @(posedge clock) begin
    if (ok_push) fifo_q[wr_q] <= {bus_q, mem_q, blk_q, bst_q};
  end
endmodule

// File: tb/tb_dma_descriptor_scheduler.sv
// tb_dma_descriptor_scheduler: directed stimulus with a queue-based scoreboard for
// status reads and descriptor issues, plus a small behavioural DMA engine.
module tb_dma_descriptor_scheduler;
  localparam logic [7:0] ID = 8'h2A;
  logic        clock = 1'b0, reset = 1'b1, ciStart = 1'b0;
  logic [7:0]  ciN = 8'd0;
  logic [31:0] ciValueA = 32'd0, ciValueB = 32'd0;
  logic        ciDone, dmaStart, dmaBusy, dmaError;
  logic [31:0] ciResult, dmaBusAddress;
  logic [8:0]  dmaMemAddress;
  logic [9:0]  dmaBlockSize;
  logic [7:0]  dmaBurstSize;
  dma_descriptor_scheduler #(.customInstructionId(ID)) dut (
    .clock(clock), .reset(reset), .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA),
    .ciValueB(ciValueB), .ciDone(ciDone), .ciResult(ciResult), .dmaBusAddress(dmaBusAddress),
    .dmaMemAddress(dmaMemAddress), .dmaBlockSize(dmaBlockSize), .dmaBurstSize(dmaBurstSize),
    .dmaStart(dmaStart), .dmaBusy(dmaBusy), .dmaError(dmaError));
  always #5 clock = ~clock;
  typedef struct { logic [58:0] d; int c; } iss_t;
  iss_t        exp_is[$];
  logic [31:0] exp_st[$];
  int tests = 0, fails = 0, cyc = 0;
  logic prev_start = 1'b0;
  logic [31:0] s_bus = 0;
  logic [8:0]  s_mem = 0;
  logic [9:0]  s_blk = 0;
  logic [7:0]  s_bst = 0;
  int m_delay = 1, m_len = 2;
  bit m_stall = 0, m_err = 0, m_never = 0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clock) begin
    if (ciStart && ciN == ID && ciValueA[2:0] == 3'd5) begin
      chk("ci_done", ciDone, 1);
      if (exp_st.size() == 0) begin
        tests++; fails++;
        $display("FAIL status_unexpected: got %0h expected none", ciResult);
      end else chk("status", ciResult, exp_st.pop_front());
    end
    if (dmaStart) begin
      chk("start_width", prev_start, 0);
      if (exp_is.size() == 0) begin
        tests++; fails++;
        $display("FAIL issue_unexpected: got bus %0h expected no dmaStart (cycle %0d)", dmaBusAddress, cyc);
      end else begin
        iss_t it;
        it = exp_is.pop_front();
        chk("issue_desc", {dmaBusAddress, dmaMemAddress, dmaBlockSize, dmaBurstSize}, it.d);
        if (it.c >= 0) chk("issue_cycle", cyc, it.c);
      end
    end
    prev_start <= dmaStart;
  end
  initial begin
    dmaBusy = 1'b0;
    dmaError = 1'b0;
    forever begin
      @(negedge clock iff dmaStart);
      @(posedge clock);
      if (!m_never) begin
        repeat (m_delay - 1) @(posedge clock);
        #1 dmaBusy = 1'b1;
        repeat (m_len) @(posedge clock);
        while (m_stall) @(posedge clock);
        #1 dmaBusy = 1'b0;
        dmaError = m_err;
        @(posedge clock);
        #1 dmaError = 1'b0;
      end
    end
  end
  function automatic logic [58:0] desc();
    return {s_bus, s_mem, s_blk, s_bst};
  endfunction
  task automatic ci(input logic [2:0] op, input logic [31:0] v);
    ciStart = 1'b1; ciN = ID; ciValueA = {29'h0ABCDEF, op}; ciValueB = v;
    @(posedge clock); #1;
    ciStart = 1'b0; ciValueA = 32'd0; ciValueB = 32'd0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic sbus(input logic [31:0] v);
    ci(3'd0, v); s_bus = v;
  endtask
  task automatic stage(input logic [31:0] b, input logic [8:0] m, input logic [9:0] k, input logic [7:0] u);
    sbus(b);
    ci(3'd1, {23'h5ABCDE, m}); s_mem = m;
    ci(3'd2, {22'h2ABCDE, k}); s_blk = k;
    ci(3'd3, {24'hABCDEF, u}); s_bst = u;
  endtask
  task automatic push(input int lat, input bit track);
    if (track) exp_is.push_back('{desc(), lat >= 0 ? cyc + lat : -1});
    ci(3'd4, 32'd0);
  endtask
  task automatic status(input logic [31:0] e);
    exp_st.push_back(e);
    ci(3'd5, 32'd0);
  endtask
  initial begin
    logic [58:0] d;
    int c;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_dma_out", {dmaBusAddress, dmaMemAddress, dmaBlockSize, dmaBurstSize, dmaStart}, 0);
    status(32'h0);
    ciStart = 1'b1; ciN = ID ^ 8'hFF; ciValueA = 32'd5; #1;
    chk("unselected_done", ciDone, 0);
    chk("unselected_result", ciResult, 0);
    ciStart = 1'b0; ciValueA = 32'd0;
    idle(1);
    // single transfer, engine busy 3 cycles after the pulse for 20 cycles
    m_delay = 3; m_len = 20;
    stage(32'h1000, 9'h010, 10'h040, 8'h0F);
    push(2, 1);
    status(32'h0000_0001);
    status(32'h0000_0011);
    idle(40);
    status(32'h0000_0100);
    // stalled engine: four accepted, fifth dropped, issue order preserved
    m_delay = 1; m_len = 4; m_stall = 1;
    for (int i = 0; i < 5; i++) begin
      sbus(32'h2000 + i);
      push(i == 0 ? 2 : -1, i < 4);
    end
    status(32'h0001_011C);
    m_stall = 0;
    idle(60);
    status(32'h0001_0500);
    // error completion halts with two descriptors still queued
    m_len = 3; m_stall = 1; m_err = 1;
    for (int i = 0; i < 3; i++) begin
      sbus(32'h3000 + i);
      push(i == 0 ? 2 : -1, i == 0);
    end
    idle(5);
    m_stall = 0;
    idle(10);
    m_err = 0;
    status(32'h0001_0522);
    idle(20);
    d = desc();
    c = cyc;
    exp_is.push_back('{{32'h3001, d[26:0]}, c + 2});
    exp_is.push_back('{{32'h3002, d[26:0]}, -1});
    ci(3'd6, 32'd0);
    status(32'h0000_0002);
    idle(40);
    status(32'h0000_0200);
    // engine never responds: 16-cycle timeout retires each descriptor
    m_never = 1;
    sbus(32'h4000);
    push(2, 1);
    sbus(32'h4001);
    push(18, 1);
    idle(50);
    status(32'h0000_0400);
    m_never = 0;
    // flush while the head is in flight
    m_len = 2; m_stall = 1;
    sbus(32'h5000); push(2, 1);
    sbus(32'h5001); push(-1, 0);
    sbus(32'h5002); push(-1, 0);
    status(32'h0000_0413);
    ci(3'd7, 32'd0);
    status(32'h0000_0410);
    m_stall = 0;
    idle(20);
    status(32'h0000_0500);
    idle(20);
    // reset in the middle of a transfer
    m_stall = 1;
    sbus(32'h6000);
    push(2, 1);
    idle(5);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midreset_dma_out", {dmaBusAddress, dmaMemAddress, dmaBlockSize, dmaBurstSize, dmaStart}, 0);
    status(32'h0);
    m_stall = 0;
    idle(10);
    s_bus = 0; s_mem = 0; s_blk = 0; s_bst = 0;
    push(2, 1);
    idle(20);
    status(32'h0000_0100);
    idle(2);
    chk("issues_drained", exp_is.size(), 0);
    chk("status_drained", exp_st.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dma_descriptor_scheduler.md
DMA_DESCRIPTOR_SCHEDULER -- requirements
Module: dma_descriptor_scheduler

Interface
REQ-001 Parameter: customInstructionId, default 8'd0, custom-instruction number this block answers to.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ciStart  input  1  custom-instruction start strobe.
REQ-005 ciN  input  8  custom-instruction number; block is selected when ciN == customInstructionId and ciStart = 1 ("selected").
REQ-006 ciValueA  input  32  bits [2:0] = opcode; bits [31:3] ignored.
REQ-007 ciValueB  input  32  operand.
REQ-008 ciDone  output  1  instruction complete.
REQ-009 ciResult  output  32  instruction result.
REQ-010 dmaBusAddress  output  32  bus start address for the DMA engine.
REQ-011 dmaMemAddress  output  9  buffer start address for the DMA engine.
REQ-012 dmaBlockSize  output  10  block size for the DMA engine.
REQ-013 dmaBurstSize  output  8  burst size for the DMA engine.
REQ-014 dmaStart  output  1  one-cycle start pulse to the DMA engine.
REQ-015 dmaBusy  input  1  DMA engine transfer in progress.
REQ-016 dmaError  input  1  DMA engine error flag; valid when dmaBusy falls.

Function
REQ-017 Opcodes:
- 0: stage bus address = ciValueB.
- 1: stage memory address = ciValueB[8:0].
- 2: stage block size = ciValueB[9:0].
- 3: stage burst size = ciValueB[7:0].
- 4: push the staged descriptor.
- 5: read status.
- 6: clear the error flag and the counters.
- 7: flush the queue.
REQ-018 ciDone = selected, combinational, for every opcode; ciResult = status word when selected with opcode 5, else 32'd0.
REQ-019 Status word:
- [2:0] queue count (0..4).
- [3] full.
- [4] active (state not IDLE/HALT).
- [5] error sticky.
- [15:8] completed count.
- [23:16] dropped count.
- all other bits 0.
REQ-020 The queue is a 4-entry FIFO of 59-bit descriptors {bus, mem, block, burst}. The staged registers are unchanged by a push.
REQ-021 A push while full discards the descriptor and increments the dropped count. The dropped count saturates at 255.
REQ-022 A push and a pop in the same cycle leave the count unchanged and keep FIFO order. The pointers wrap modulo 4.
REQ-023 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HALT.
REQ-024 IDLE -> ISSUE when count > 0 and error sticky = 0.
REQ-025 ISSUE:
- Latch the FIFO head into the dma* output registers.
- Assert dmaStart for exactly this one cycle.
- Go to WAIT_BUSY.
REQ-026 WAIT_BUSY:
- dmaBusy = 1 -> WAIT_DONE.
- If dmaBusy stays 0 for 16 consecutive cycles, treat the transfer as completed without error: pop, increment completed count, go to IDLE.
REQ-027 WAIT_DONE, when dmaBusy = 0:
- Pop the head.
- If dmaError = 1: set error sticky and go to HALT.
- Else: increment completed count (saturates at 255) and go to IDLE.
REQ-028 HALT: stays until opcode 6, then goes to IDLE next cycle; queued descriptors are preserved.
REQ-029 The dma* outputs hold their value from ISSUE until the next ISSUE; they are never changed while in WAIT_BUSY or WAIT_DONE.
REQ-030 Opcode 7 empties all queued (not in-flight) entries; the in-flight transfer completes normally. If a flush and a pop coincide, the flush wins and the count becomes 0.
REQ-031 Opcode 6 in a state other than HALT clears sticky and counters only; the FSM is unaffected.
REQ-032 The minimum latency from a push into an empty queue in IDLE to dmaStart is 2 cycles: the push registers in cycle N, IDLE sees count > 0 in N+1, ISSUE/dmaStart is in N+2.

Reset
REQ-033 While reset = 1:
- State = IDLE.
- FIFO pointers and count = 0.
- Staged registers, dma* outputs, counters and error sticky = 0.
- dmaStart = 0.
REQ-034 ciDone and ciResult remain combinational during reset.
REQ-035 Reset asserted mid-transfer abandons the descriptor with no further dmaStart; dmaBusy is ignored until the state is IDLE.

Verification
REQ-036 Stage bus=0x1000, mem=0x010, block=0x040, burst=0x0F; push; then the DMA model asserts dmaBusy 3 cycles after the pulse and holds it 20 cycles. Required:
- dmaStart high exactly one cycle, 2 cycles after the push.
- The outputs carry the staged values.
- After dmaBusy falls: status[15:8]=1, status[2:0]=0.
REQ-037 Five pushes with the engine stalled (dmaBusy held 1) -> status count=4, full=1, dropped=1 (dropped counts the excess push only); descriptors issue in push order.
REQ-038 Fall of dmaBusy with dmaError=1 -> state HALT, status[5]=1, no further dmaStart with 2 entries queued; after opcode 6 -> next descriptor issues, status[5]=0.
REQ-039 dmaBusy never asserts after dmaStart -> after 16 cycles the descriptor retires, completed count increments, the next entry issues.
REQ-040 Opcode 7 during WAIT_DONE with 3 queued -> count=0 next cycle; the in-flight transfer completes (completed count +1); no further dmaStart.
REQ-041 Reset asserted during WAIT_DONE -> next cycle all status bits 0, dma* outputs 0, dmaStart 0.
